clock_time_keeper: RTL and testbench

- Parametrised timekeeping core for the board clock: BCD hh:mm:ss with AM/PM, a 12h or 24h build mode, and an edit mode driven by single-cycle button pulses.
- Sits between the button debouncers and the LCD driver; `o_update_pulse` tells the LCD driver to redraw.
- The second tick divider is parametrised so that benches can run at reduced `TICK_DIV`.

---
 rtl/clock_time_keeper.sv | 196 +++++++++++++++++++
 tb/tb_clock_time_keeper.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_keeper.sv
// BCD hh:mm:ss timekeeper with 12h/24h build mode and a shadow-register edit mode.
// Display shows live time in RUN and the shadow copy in EDIT; o_update_pulse strobes on every visible change.
module clock_time_keeper #(
    parameter int unsigned TICK_DIV = 12000000,
    parameter bit          IS_24H   = 1'b0,
    parameter logic [7:0]  RESET_HH = 8'h12,
    parameter logic [7:0]  RESET_MM = 8'h00,
    parameter logic [7:0]  RESET_SS = 8'h00,
    parameter bit          RESET_PM = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_wr_pls,
    input  logic       i_sel_inc_pls,
    input  logic       i_sel_dec_pls,
    input  logic       i_val_inc_pls,
    input  logic       i_val_dec_pls,
    output logic [7:0] o_hh,
    output logic [7:0] o_mm,
    output logic [7:0] o_ss,
    output logic       o_pm,
    output logic       o_edit,
    output logic [1:0] o_sel,
    output logic       o_update_pulse
);

    localparam int unsigned       CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [7:0]        HH_MIN  = IS_24H ? 8'h00 : 8'h01;
    localparam logic [7:0]        HH_MAX  = IS_24H ? 8'h23 : 8'h12;
    localparam logic [1:0]        SEL_MAX = IS_24H ? 2'd2 : 2'd3;

    typedef enum logic {ST_RUN, ST_EDIT} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       live_hh, live_mm, live_ss, live_hh_n, live_mm_n, live_ss_n;
    logic [7:0]       sh_hh, sh_mm, sh_ss, sh_hh_n, sh_mm_n, sh_ss_n;
    logic             live_pm, live_pm_n, sh_pm, sh_pm_n;
    logic [1:0]       sel, sel_n;
    logic             upd, upd_n;
    logic             tick_c, val_up_c, val_dn_c;
    logic [7:0]       disp_hh;

    // BCD increment/decrement wrapping within [lo, hi], no carry out
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi);
        logic [7:0] r;
        if (v == hi)               r = lo;
        else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
        else                       r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi);
        logic [7:0] r;
        if (v == lo)               r = hi;
        else if (v[3:0] == 4'd0)   r = {v[7:4] - 4'd1, 4'd9};
        else                       r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    assign tick_c   = (cnt == CNT_MAX);
    assign val_up_c = i_val_inc_pls & ~i_val_dec_pls;
    assign val_dn_c = i_val_dec_pls & ~i_val_inc_pls;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= ST_RUN;
            cnt     <= '0;
            live_hh <= RESET_HH;
            live_mm <= RESET_MM;
            live_ss <= RESET_SS;
            live_pm <= RESET_PM;
            sh_hh   <= RESET_HH;
            sh_mm   <= RESET_MM;
            sh_ss   <= RESET_SS;
            sh_pm   <= RESET_PM;
            sel     <= 2'd0;
            upd     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            live_hh <= live_hh_n;
            live_mm <= live_mm_n;
            live_ss <= live_ss_n;
            live_pm <= live_pm_n;
            sh_hh   <= sh_hh_n;
            sh_mm   <= sh_mm_n;
            sh_ss   <= sh_ss_n;
            sh_pm   <= sh_pm_n;
            sel     <= sel_n;
            upd     <= upd_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = tick_c ? '0 : cnt + CNT_W'(1);
        live_hh_n = live_hh;
        live_mm_n = live_mm;
        live_ss_n = live_ss;
        live_pm_n = live_pm;
        sh_hh_n   = sh_hh;
        sh_mm_n   = sh_mm;
        sh_ss_n   = sh_ss;
        sh_pm_n   = sh_pm;
        sel_n     = sel;
        upd_n     = 1'b0;

        // live time advances on every tick regardless of mode
        if (tick_c) begin
            live_ss_n = bcd_inc(live_ss, 8'h00, 8'h59);
            if (live_ss == 8'h59) begin
                live_mm_n = bcd_inc(live_mm, 8'h00, 8'h59);
                if (live_mm == 8'h59) begin
                    live_hh_n = bcd_inc(live_hh, HH_MIN, HH_MAX);
                    if (!IS_24H && live_hh == 8'h11) live_pm_n = ~live_pm;
                end
            end
        end

        case (state)
            ST_RUN: begin
                if (tick_c) upd_n = 1'b1;
                if (i_wr_pls) begin
                    state_n = ST_EDIT;
                    sh_hh_n = live_hh_n;
                    sh_mm_n = live_mm_n;
                    sh_ss_n = live_ss_n;
                    sh_pm_n = live_pm_n;
                    sel_n   = 2'd0;
                    upd_n   = 1'b1;
                end
            end
            ST_EDIT: begin
                if (i_wr_pls) begin
                    // commit overrides any tick landing in this cycle
                    state_n   = ST_RUN;
                    live_hh_n = sh_hh;
                    live_mm_n = sh_mm;
                    live_ss_n = sh_ss;
                    live_pm_n = sh_pm;
                    cnt_n     = '0;
                    upd_n     = 1'b1;
                end else begin
                    if (val_up_c || val_dn_c) begin
                        case (sel)
                            2'd0: begin
                                sh_hh_n = val_up_c ? bcd_inc(sh_hh, HH_MIN, HH_MAX)
                                                   : bcd_dec(sh_hh, HH_MIN, HH_MAX);
                                upd_n   = 1'b1;
                            end
                            2'd1: begin
                                sh_mm_n = val_up_c ? bcd_inc(sh_mm, 8'h00, 8'h59)
                                                   : bcd_dec(sh_mm, 8'h00, 8'h59);
                                upd_n   = 1'b1;
                            end
                            2'd2: begin
                                sh_ss_n = val_up_c ? bcd_inc(sh_ss, 8'h00, 8'h59)
                                                   : bcd_dec(sh_ss, 8'h00, 8'h59);
                                upd_n   = 1'b1;
                            end
                            default: begin
                                if (!IS_24H) begin
                                    sh_pm_n = ~sh_pm;
                                    upd_n   = 1'b1;
                                end
                            end
                        endcase
                    end
                    if (i_sel_inc_pls && !i_sel_dec_pls) begin
                        sel_n = (sel == SEL_MAX) ? 2'd0 : sel + 2'd1;
                        upd_n = 1'b1;
                    end else if (i_sel_dec_pls && !i_sel_inc_pls) begin
                        sel_n = (sel == 2'd0) ? SEL_MAX : sel - 2'd1;
                        upd_n = 1'b1;
                    end
                end
            end
            default: state_n = ST_RUN;
        endcase
    end

    assign disp_hh        = (state == ST_EDIT) ? sh_hh : live_hh;
    assign o_hh           = disp_hh;
    assign o_mm           = (state == ST_EDIT) ? sh_mm : live_mm;
    assign o_ss           = (state == ST_EDIT) ? sh_ss : live_ss;
    assign o_pm           = IS_24H ? (disp_hh >= 8'h12)
                                   : ((state == ST_EDIT) ? sh_pm : live_pm);
    assign o_edit         = (state == ST_EDIT);
    assign o_sel          = sel;
    assign o_update_pulse = upd;

endmodule

// File: tb/tb_clock_time_keeper.sv
// Scoreboard bench for clock_time_keeper: a 12h and a 24h instance at TICK_DIV=4.
// Stimulus pushes the expected display per update strobe; monitors pop and compare.
module tb_clock_time_keeper;

    localparam logic [4:0] P_WR = 5'b10000;
    localparam logic [4:0] P_SI = 5'b01000;
    localparam logic [4:0] P_SD = 5'b00100;
    localparam logic [4:0] P_VI = 5'b00010;
    localparam logic [4:0] P_VD = 5'b00001;

    typedef struct {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic       pm;
        logic       edit;
        logic [1:0] sel;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, wr_a, si_a, sd_a, vi_a, vd_a;
    logic [7:0] hh_a, mm_a, ss_a;
    logic       pm_a, edit_a, upd_a;
    logic [1:0] sel_a;
    logic       rst_b, wr_b, si_b, sd_b, vi_b, vd_b;
    logic [7:0] hh_b, mm_b, ss_b;
    logic       pm_b, edit_b, upd_b;
    logic [1:0] sel_b;

    int   total = 0;
    int   bad   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    clock_time_keeper #(.TICK_DIV(4), .IS_24H(1'b0), .RESET_HH(8'h12), .RESET_MM(8'h00),
                        .RESET_SS(8'h00), .RESET_PM(1'b0)) dut_a (
        .i_clk(clk), .i_reset(rst_a), .i_wr_pls(wr_a), .i_sel_inc_pls(si_a),
        .i_sel_dec_pls(sd_a), .i_val_inc_pls(vi_a), .i_val_dec_pls(vd_a),
        .o_hh(hh_a), .o_mm(mm_a), .o_ss(ss_a), .o_pm(pm_a), .o_edit(edit_a),
        .o_sel(sel_a), .o_update_pulse(upd_a));

    clock_time_keeper #(.TICK_DIV(4), .IS_24H(1'b1), .RESET_HH(8'h23), .RESET_MM(8'h59),
                        .RESET_SS(8'h59), .RESET_PM(1'b0)) dut_b (
        .i_clk(clk), .i_reset(rst_b), .i_wr_pls(wr_b), .i_sel_inc_pls(si_b),
        .i_sel_dec_pls(sd_b), .i_val_inc_pls(vi_b), .i_val_dec_pls(vd_b),
        .o_hh(hh_b), .o_mm(mm_b), .o_ss(ss_b), .o_pm(pm_b), .o_edit(edit_b),
        .o_sel(sel_b), .o_update_pulse(upd_b));

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                                input logic p, input logic e, input logic [1:0] sl);
        exp_t x;
        x.hh = h; x.mm = m; x.ss = s; x.pm = p; x.edit = e; x.sel = sl;
        return x;
    endfunction

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic pa(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                      input logic p, input logic e, input logic [1:0] sl);
        q_a.push_back(mk(h, m, s, p, e, sl));
    endtask

    task automatic pb(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                      input logic p, input logic e, input logic [1:0] sl);
        q_b.push_back(mk(h, m, s, p, e, sl));
    endtask

    // one-cycle pulse; called just after a rising edge, returns just after the next one
    task automatic pul_a(input logic [4:0] m);
        {wr_a, si_a, sd_a, vi_a, vd_a} = m;
        @(posedge clk); #1;
        {wr_a, si_a, sd_a, vi_a, vd_a} = 5'b0;
    endtask

    task automatic pul_b(input logic [4:0] m);
        {wr_b, si_b, sd_b, vi_b, vd_b} = m;
        @(posedge clk); #1;
        {wr_b, si_b, sd_b, vi_b, vd_b} = 5'b0;
    endtask

    // monitors: every update strobe consumes one expected display
    always @(negedge clk) begin
        if (!rst_a && upd_a) begin
            if (q_a.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected_update got=%h:%h:%h want=none", hh_a, mm_a, ss_a);
            end else begin
                ea = q_a.pop_front();
                cmp("a_display", {hh_a, mm_a, ss_a, pm_a, edit_a}, {ea.hh, ea.mm, ea.ss, ea.pm, ea.edit});
                if (ea.edit) cmp("a_sel", 64'(sel_a), 64'(ea.sel));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b && upd_b) begin
            if (q_b.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected_update got=%h:%h:%h want=none", hh_b, mm_b, ss_b);
            end else begin
                eb = q_b.pop_front();
                cmp("b_display", {hh_b, mm_b, ss_b, pm_b, edit_b}, {eb.hh, eb.mm, eb.ss, eb.pm, eb.edit});
                if (eb.edit) cmp("b_sel", 64'(sel_b), 64'(eb.sel));
            end
        end
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        {wr_a, si_a, sd_a, vi_a, vd_a} = 5'b0;
        {wr_b, si_b, sd_b, vi_b, vd_b} = 5'b0;
        repeat (2) @(posedge clk);
        #1;
        cmp("a_reset", {hh_a, mm_a, ss_a, pm_a, edit_a, sel_a, upd_a},
            {8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0});
        rst_a = 1'b0;

        // free-running: one strobe every 4 cycles for a full minute
        for (int i = 1; i <= 60; i++) pa(8'h12, bcd(i / 60), bcd(i % 60), 1'b0, 1'b0, 2'd0);
        repeat (240) @(posedge clk);
        #1;
        cmp("a_one_minute", {hh_a, mm_a, ss_a}, {8'h12, 8'h01, 8'h00});

        // edit: hh 12->01, mm 01->00->59, inc+dec cancels, commit
        pa(8'h12, 8'h01, 8'h00, 1'b0, 1'b1, 2'd0); pul_a(P_WR);
        pa(8'h01, 8'h01, 8'h00, 1'b0, 1'b1, 2'd0); pul_a(P_VI);
        pa(8'h01, 8'h01, 8'h00, 1'b0, 1'b1, 2'd1); pul_a(P_SI);
        pa(8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 2'd1); pul_a(P_VD);
        pa(8'h01, 8'h59, 8'h00, 1'b0, 1'b1, 2'd1); pul_a(P_VD);
        pul_a(P_VI | P_VD);
        cmp("a_incdec_nochange", {hh_a, mm_a, ss_a, sel_a}, {8'h01, 8'h59, 8'h00, 2'd1});
        pa(8'h01, 8'h59, 8'h00, 1'b0, 1'b0, 2'd0); pul_a(P_WR);
        pa(8'h01, 8'h59, 8'h01, 1'b0, 1'b0, 2'd0);
        repeat (3) @(posedge clk);
        #1;
        cmp("a_commit_hold", {edit_a, ss_a}, {1'b0, 8'h00});
        @(posedge clk);
        #1;
        cmp("a_commit_tick", 64'(ss_a), 64'(8'h01));

        // preload 11:59:59 AM, exercising sel+val together and sel wrap
        pa(8'h01, 8'h59, 8'h01, 1'b0, 1'b1, 2'd0); pul_a(P_WR);
        pa(8'h02, 8'h59, 8'h01, 1'b0, 1'b1, 2'd1); pul_a(P_SI | P_VI);
        pa(8'h02, 8'h59, 8'h01, 1'b0, 1'b1, 2'd0); pul_a(P_SD);
        pa(8'h01, 8'h59, 8'h01, 1'b0, 1'b1, 2'd0); pul_a(P_VD);
        pa(8'h12, 8'h59, 8'h01, 1'b0, 1'b1, 2'd0); pul_a(P_VD);
        pa(8'h11, 8'h59, 8'h01, 1'b0, 1'b1, 2'd0); pul_a(P_VD);
        pa(8'h11, 8'h59, 8'h01, 1'b0, 1'b1, 2'd1); pul_a(P_SI);
        pa(8'h11, 8'h59, 8'h01, 1'b0, 1'b1, 2'd2); pul_a(P_SI);
        pa(8'h11, 8'h59, 8'h00, 1'b0, 1'b1, 2'd2); pul_a(P_VD);
        pa(8'h11, 8'h59, 8'h59, 1'b0, 1'b1, 2'd2); pul_a(P_VD);
        pa(8'h11, 8'h59, 8'h59, 1'b0, 1'b1, 2'd3); pul_a(P_SI);
        pa(8'h11, 8'h59, 8'h59, 1'b0, 1'b1, 2'd0); pul_a(P_SI);
        pa(8'h11, 8'h59, 8'h59, 1'b0, 1'b0, 2'd0); pul_a(P_WR | P_VI);
        pa(8'h12, 8'h00, 8'h00, 1'b1, 1'b0, 2'd0);
        repeat (4) @(posedge clk);
        #1;

        // preload 12:59:59 PM, next tick gives 01:00:00 PM
        pa(8'h12, 8'h00, 8'h00, 1'b1, 1'b1, 2'd0); pul_a(P_WR);
        pa(8'h12, 8'h00, 8'h00, 1'b1, 1'b1, 2'd1); pul_a(P_SI);
        pa(8'h12, 8'h59, 8'h00, 1'b1, 1'b1, 2'd1); pul_a(P_VD);
        pa(8'h12, 8'h59, 8'h00, 1'b1, 1'b1, 2'd2); pul_a(P_SI);
        pa(8'h12, 8'h59, 8'h59, 1'b1, 1'b1, 2'd2); pul_a(P_VD);
        pa(8'h12, 8'h59, 8'h59, 1'b1, 1'b0, 2'd0); pul_a(P_WR);
        pa(8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 2'd0);
        repeat (4) @(posedge clk);
        #1;

        // edit hh to 05, then reset mid-edit
        pa(8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 2'd0); pul_a(P_WR);
        for (int h = 2; h <= 5; h++) begin
            pa(bcd(h), 8'h00, 8'h00, 1'b1, 1'b1, 2'd0);
            pul_a(P_VI);
        end
        @(negedge clk);
        #1;
        rst_a = 1'b1;
        #1;
        cmp("a_reset_midedit", {hh_a, mm_a, ss_a, pm_a, edit_a, sel_a, upd_a},
            {8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0});
        cmp("a_queue_drained", 64'(q_a.size()), 64'd0);

        // 24h instance: 23:59:59 -> 00:00:00, sel wraps 2->0
        @(posedge clk);
        #1;
        cmp("b_reset", {hh_b, mm_b, ss_b, pm_b, edit_b}, {8'h23, 8'h59, 8'h59, 1'b1, 1'b0});
        rst_b = 1'b0;
        pb(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
        repeat (4) @(posedge clk);
        #1;
        cmp("b_midnight_pm", {hh_b, pm_b}, {8'h00, 1'b0});
        pb(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 2'd0); pul_b(P_WR);
        pb(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 2'd1); pul_b(P_SI);
        pb(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 2'd2); pul_b(P_SI);
        pb(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 2'd0); pul_b(P_SI);
        pb(8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 2'd0); pul_b(P_VI);
        @(negedge clk);
        #1;
        cmp("b_queue_drained", 64'(q_b.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
